mem_arbiter: RTL and testbench

- Shares one single-port synchronous RAM (1-cycle read latency, byte write enables) between the instruction-fetch requester and the data-access requester.
- Lets the pipeline run from a unified instruction/data memory.
- Per-cycle grant is fixed-priority (data first) with a starvation guard for fetch.
- Routes each read response back to its owner one cycle after grant; honours pipeline cancel for in-flight fetches.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arb_starve.sv | 38 +++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
// Response-owner encoding and the byte-enable field width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

    localparam int BE_W = 4;

endpackage

// File: rtl/mem_arb_starve.sv
// Fetch starvation guard: counts consecutive denied fetch cycles, saturating at STARVE_MAX.
// Latency: force flag is a function of the registered count (no comb path from gnt).
// Backpressure: none; the counter only observes req/gnt/cancel.
module mem_arb_starve #(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic gnt,
    input  logic cancel,
    output logic force_fetch
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A grant, a dropped request or a flush all restart the count.
    always_comb begin
        cnt_d = '0;
        if (req && !gnt && !cancel) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_fetch = req & ~cancel & (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter, data-first with fetch starvation guard; MEM_ARB_STAT_EN adds stat counters.
// Latency: grant combinational, read response one cycle after grant.
// Backpressure: an ungranted requester must hold request/address; nothing is queued.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cancel,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [BE_W-1:0]   d_wen,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_en,
    output logic [BE_W-1:0]   ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef MEM_ARB_STAT_EN
    ,
    output logic [31:0]       stat_conflicts,
    output logic [31:0]       stat_starve
`endif
);

    owner_e owner_q, owner_d;
    logic   force_fetch;
    logic   unused_addr_bits;

    mem_arb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk         (clk),
        .reset       (reset),
        .req         (i_req),
        .gnt         (i_gnt),
        .cancel      (cancel),
        .force_fetch (force_fetch)
    );

    assign d_gnt = ~reset & d_req & ~force_fetch;
    assign i_gnt = ~reset & i_req & ~cancel & ~d_gnt;

    assign ram_en    = i_gnt | d_gnt;
    assign ram_addr  = d_gnt ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];
    assign ram_wen   = d_gnt ? d_wen : '0;
    assign ram_wdata = d_wdata;

    // Only the word-index bits reach the RAM; the rest wrap away.
    assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

    always_comb begin
        owner_d = OWN_IDLE;
        if (i_gnt) begin
            owner_d = OWN_INST;
        end else if (d_gnt) begin
            owner_d = OWN_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_IDLE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // A response still in flight when reset arrives is dropped.
    assign i_rvalid = ~reset & (owner_q == OWN_INST) & ~cancel;
    assign d_rvalid = ~reset & (owner_q == OWN_DATA);
    assign i_rdata  = (owner_q == OWN_INST) ? ram_rdata : '0;
    assign d_rdata  = (owner_q == OWN_DATA) ? ram_rdata : '0;

`ifdef MEM_ARB_STAT_EN
    logic [31:0] stat_conflicts_q, stat_conflicts_d;
    logic [31:0] stat_starve_q, stat_starve_d;

    // A fetch grant while data was also asking can only come from the guard.
    always_comb begin
        stat_conflicts_d = stat_conflicts_q;
        stat_starve_d    = stat_starve_q;
        if (i_req && d_req && (stat_conflicts_q != '1)) begin
            stat_conflicts_d = stat_conflicts_q + 32'd1;
        end
        if (i_gnt && d_req && (stat_starve_q != '1)) begin
            stat_starve_d = stat_starve_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_conflicts_q <= '0;
            stat_starve_q    <= '0;
        end else begin
            stat_conflicts_q <= stat_conflicts_d;
            stat_starve_q    <= stat_starve_d;
        end
    end

    assign stat_conflicts = stat_conflicts_q;
    assign stat_starve    = stat_starve_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a reference model.
module tb_mem_arbiter;

    localparam int SM = 3;

    logic        clk;
    logic        reset;
    logic        cancel;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [3:0]  d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
`ifdef MEM_ARB_STAT_EN
    logic [31:0] stat_conflicts;
    logic [31:0] stat_starve;
`endif

    mem_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_MAX(SM)) dut (
        .clk       (clk),
        .reset     (reset),
        .cancel    (cancel),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_wen     (d_wen),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .ram_en    (ram_en),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
`ifdef MEM_ARB_STAT_EN
        ,
        .stat_conflicts (stat_conflicts),
        .stat_starve    (stat_starve)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Physical RAM driven by the DUT's RAM port.
    logic [31:0] ram_mem [0:255];
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= ram_mem[ram_addr];
            for (int b = 0; b < 4; b++) begin
                if (ram_wen[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state: memory image, denied-fetch streak, the access awaiting its response.
    logic [31:0] ref_mem [0:255];
    int          m_streak;
    bit          m_pend_i, m_pend_d, m_pend_rd;
    logic [31:0] m_pend_dat;
    int unsigned m_conf, m_starve;

    logic        obs_i_gnt, obs_d_gnt, obs_i_rvalid, obs_d_rvalid;
    logic [7:0]  obs_ram_addr;
    logic [31:0] obs_i_rdata, obs_d_rdata;

    task automatic step(input logic rst, input logic can, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic [3:0] dw, input logic [31:0] da,
                        input logic [31:0] dwd);
        bit          fetch_live, e_i, e_d;
        logic [7:0]  iw, dwi;
        logic [31:0] old;
        @(negedge clk);
        reset = rst; cancel = can; i_req = ir; i_addr = ia;
        d_req = dr; d_wen = dw; d_addr = da; d_wdata = dwd;
        #1;
        iw  = ia[9:2];
        dwi = da[9:2];
        fetch_live = ir && !can && !rst;
        e_d = !rst && dr && !(fetch_live && m_streak == SM);
        e_i = fetch_live && !e_d;

        chk("i_gnt", 32'(i_gnt), 32'(e_i));
        chk("d_gnt", 32'(d_gnt), 32'(e_d));
        chk("ram_en", 32'(ram_en), 32'(e_i || e_d));
        chk("ram_wen", 32'(ram_wen), e_d ? 32'(dw) : 32'd0);
        if (e_i) chk("ram_addr_i", 32'(ram_addr), 32'(iw));
        if (e_d) chk("ram_addr_d", 32'(ram_addr), 32'(dwi));
        if (e_d && dw != 4'd0) chk("ram_wdata", ram_wdata, dwd);
        if (!rst) begin
            chk("i_rvalid", 32'(i_rvalid), 32'(m_pend_i && !can));
            chk("d_rvalid", 32'(d_rvalid), 32'(m_pend_d));
            chk("i_rdata", i_rdata, m_pend_i ? m_pend_dat : 32'd0);
            if (!m_pend_d) chk("d_rdata_idle", d_rdata, 32'd0);
            else if (m_pend_rd) chk("d_rdata", d_rdata, m_pend_dat);
        end
`ifdef MEM_ARB_STAT_EN
        chk("stat_conflicts", stat_conflicts, m_conf);
        chk("stat_starve", stat_starve, m_starve);
`endif
        obs_i_gnt = i_gnt; obs_d_gnt = d_gnt; obs_i_rvalid = i_rvalid; obs_d_rvalid = d_rvalid;
        obs_ram_addr = ram_addr; obs_i_rdata = i_rdata; obs_d_rdata = d_rdata;

        // Advance the model across the coming rising edge.
        m_pend_i = 0; m_pend_d = 0; m_pend_rd = 0; m_pend_dat = 32'd0;
        if (rst) begin
            m_streak = 0; m_conf = 0; m_starve = 0;
        end else begin
            if (ir && dr) m_conf++;
            if (e_i && dr) m_starve++;
            if (ir && !e_i && !can) m_streak = (m_streak < SM) ? m_streak + 1 : SM;
            else m_streak = 0;
            if (e_i) begin
                m_pend_i = 1; m_pend_dat = ref_mem[iw];
            end else if (e_d) begin
                m_pend_d = 1; m_pend_rd = (dw == 4'd0); m_pend_dat = ref_mem[dwi];
                old = ref_mem[dwi];
                for (int b = 0; b < 4; b++) if (dw[b]) old[8*b +: 8] = dwd[8*b +: 8];
                ref_mem[dwi] = old;
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    initial begin
        logic        r_ir, r_dr, r_can, r_rst;
        logic [31:0] r_ia, r_da, r_wd;
        logic [3:0]  r_dw;
        for (int k = 0; k < 256; k++) begin
            ram_mem[k] = 32'hA5A5_0000 | k;
            ref_mem[k] = 32'hA5A5_0000 | k;
        end
        ram_mem[8] = 32'hFFFF_FFFF;
        ref_mem[8] = 32'hFFFF_FFFF;
        m_streak = 0; m_pend_i = 0; m_pend_d = 0; m_pend_rd = 0; m_pend_dat = 0;
        m_conf = 0; m_starve = 0;
        reset = 1; cancel = 0; i_req = 0; i_addr = 0; d_req = 0; d_wen = 0; d_addr = 0; d_wdata = 0;

        // Reset with both requesters asking: nothing may be granted.
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 4'd0, 32'h40, 32'd0);
            chk("rst_i_gnt", 32'(obs_i_gnt), 32'd0);
            chk("rst_d_gnt", 32'(obs_d_gnt), 32'd0);
        end
        idle();
        chk("post_rst_d_rvalid", 32'(obs_d_rvalid), 32'd0);

        // Fetch-only stream from byte address 0x10.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 4'd0, 32'd0, 32'd0);
            chk("fo_gnt", 32'(obs_i_gnt), 32'd1);
            chk("fo_addr", 32'(obs_ram_addr), 32'd4);
            if (k > 0) begin
                chk("fo_rvalid", 32'(obs_i_rvalid), 32'd1);
                chk("fo_rdata", obs_i_rdata, 32'hA5A5_0004);
            end
        end
        idle();
        chk("fo_last_rdata", obs_i_rdata, 32'hA5A5_0004);

        // Five conflict cycles from a fresh reset: data, data, data, fetch, data.
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 4'd0, 32'h40, 32'd0);
            chk("cf_i_gnt", 32'(obs_i_gnt), (k == 3) ? 32'd1 : 32'd0);
            chk("cf_d_gnt", 32'(obs_d_gnt), (k == 3) ? 32'd0 : 32'd1);
        end
        idle();
`ifdef MEM_ARB_STAT_EN
        chk("st_conflicts5", stat_conflicts, 32'd5);
        chk("st_starve1", stat_starve, 32'd1);
`endif

        // Partial store over 0xFFFF_FFFF, then load it back.
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 4'b0011, 32'h20, 32'h1234_5678);
        chk("st_gnt", 32'(obs_d_gnt), 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 4'b0000, 32'h20, 32'd0);
        chk("st_rvalid", 32'(obs_d_rvalid), 32'd1);
        idle();
        chk("ld_rvalid", 32'(obs_d_rvalid), 32'd1);
        chk("ld_rdata", obs_d_rdata, 32'hFFFF_5678);

        // Cancel in the response cycle, then the streak must restart from zero.
        step(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 4'd0, 32'd0, 32'd0);
        chk("cn_gnt", 32'(obs_i_gnt), 32'd1);
        step(1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 4'd0, 32'd0, 32'd0);
        chk("cn_no_gnt", 32'(obs_i_gnt), 32'd0);
        chk("cn_no_rvalid", 32'(obs_i_rvalid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 4'd0, 32'h44, 32'd0);
            chk("cn_streak_i", 32'(obs_i_gnt), (k == 3) ? 32'd1 : 32'd0);
        end

        // Reset while a data read is in flight.
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 4'd0, 32'h48, 32'd0);
        chk("rm_gnt", 32'(obs_d_gnt), 32'd1);
        step(1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 4'd0, 32'h48, 32'd0);
        chk("rm_i_gnt", 32'(obs_i_gnt), 32'd0);
        chk("rm_d_gnt", 32'(obs_d_gnt), 32'd0);
        idle();
        chk("rm_d_rvalid", 32'(obs_d_rvalid), 32'd0);
        chk("rm_i_rvalid", 32'(obs_i_rvalid), 32'd0);

        // Random traffic; ungranted requests are held stable.
        r_ir = 0; r_dr = 0; r_ia = 0; r_da = 0; r_dw = 0; r_wd = 0;
        for (int c = 0; c < 800; c++) begin
            r_rst = ($urandom_range(63) == 0);
            r_can = ($urandom_range(7) == 0);
            if (!(r_ir && !obs_i_gnt)) begin
                r_ir = $urandom_range(2) != 0;
                r_ia = $urandom;
            end
            if (!(r_dr && !obs_d_gnt)) begin
                r_dr = $urandom_range(2) != 0;
                r_da = $urandom;
                r_dw = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom);
                r_wd = $urandom;
            end
            step(r_rst, r_can, r_ir, r_ia, r_dr, r_dw, r_da, r_wd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
